reg_bank_wb: RTL and testbench



---
 rtl/reg_bank_wb.sv | 96 +++++++++
 tb/tb_reg_bank_wb.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/reg_bank_wb.sv
// 32x32 MIPS register bank with a one-entry write-back buffer.
// Writes commit one edge after acceptance; optional read bypass.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   RegWrite         write request this cycle
//   WriteReg         destination index (reg 0 writes are dropped)
//   WriteData        write data
//   ReadReg1/2       read indices
//   ReadData1/2      combinational read data
//   wb_pending       registered; buffer holds an uncommitted write
module reg_bank_wb #(
  parameter int          SP_REG  = 29,
  parameter logic [31:0] SP_INIT = 32'd227,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic        wb_pending
);

  logic [31:0] regs_q [32];

  logic        pend_valid_q, pend_valid_d;
  logic [4:0]  pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;

  logic accept;

  assign accept = RegWrite && (WriteReg != 5'd0);

  always_comb begin
    pend_valid_d = accept;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (accept) begin
      pend_addr_d = WriteReg;
      pend_data_d = WriteData;
    end
  end

  // The buffered write commits on the same edge that may
  // accept the next one, so one write per cycle is sustained.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == SP_REG) ? SP_INIT : 32'h0;
      end
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 5'd0;
      pend_data_q  <= 32'h0;
    end else begin
      if (pend_valid_q) begin
        regs_q[pend_addr_q] <= pend_data_q;
      end
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  logic hit1, hit2;

  assign hit1 = BYPASS && pend_valid_q &&
                (ReadReg1 == pend_addr_q);
  assign hit2 = BYPASS && pend_valid_q &&
                (ReadReg2 == pend_addr_q);

  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    if (ReadReg1 == 5'd0) begin
      ReadData1 = 32'h0;
    end else if (hit1) begin
      ReadData1 = pend_data_q;
    end
  end

  always_comb begin
    ReadData2 = regs_q[ReadReg2];
    if (ReadReg2 == 5'd0) begin
      ReadData2 = 32'h0;
    end else if (hit2) begin
      ReadData2 = pend_data_q;
    end
  end

  assign wb_pending = pend_valid_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Testbench for reg_bank_wb: bypassing and non-bypassing
// instances driven in lockstep from a vector table.
module tb_reg_bank_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        pend, pend_nb;

  always #5 clk = ~clk;

  reg_bank_wb #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite),
    .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1), .ReadData2(rd2), .wb_pending(pend)
  );

  reg_bank_wb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite(RegWrite),
    .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1_nb), .ReadData2(rd2_nb),
    .wb_pending(pend_nb)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ep;
    logic [31:0] e1nb;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  vec_t exp_q [$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we,
                       input logic [4:0] wa,
                       input logic [31:0] wd,
                       input logic [4:0] r1,
                       input logic [4:0] r2);
    reset     = rst;
    RegWrite  = we;
    WriteReg  = wa;
    WriteData = wd;
    ReadReg1  = r1;
    ReadReg2  = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    // rst we wa wd r1 r2 | e1 e2 ep e1nb  (sampled after edge)
    vecs[0]  = '{1, 0, 0,  0,            29, 5,
                 227,          0,            0, 227};
    vecs[1]  = '{0, 1, 8,  32'hDEADBEEF, 8,  29,
                 32'hDEADBEEF, 227,          1, 0};
    vecs[2]  = '{0, 0, 0,  0,            8,  8,
                 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    vecs[3]  = '{0, 1, 0,  32'h1234,     0,  8,
                 0,            32'hDEADBEEF, 0, 0};
    vecs[4]  = '{0, 1, 9,  1,            9,  9,
                 1,            1,            1, 0};
    vecs[5]  = '{0, 1, 9,  2,            9,  8,
                 2,            32'hDEADBEEF, 1, 1};
    vecs[6]  = '{0, 0, 0,  0,            9,  9,
                 2,            2,            0, 2};
    vecs[7]  = '{0, 1, 31, 32'hABCD,     31, 29,
                 32'hABCD,     227,          1, 0};
    vecs[8]  = '{1, 0, 0,  0,            31, 29,
                 0,            227,          0, 0};
    vecs[9]  = '{1, 1, 4,  7,            4,  0,
                 0,            0,            0, 0};
    vecs[10] = '{0, 0, 0,  0,            4,  29,
                 0,            227,          0, 0};
    vecs[11] = '{0, 1, 12, 32'h55AA,     12, 13,
                 32'h55AA,     0,            1, 0};
    vecs[12] = '{0, 1, 13, 32'h77,       12, 13,
                 32'h55AA,     32'h77,       1, 32'h55AA};
    vecs[13] = '{0, 0, 0,  0,            13, 12,
                 32'h77,       32'h55AA,     0, 32'h77};

    drive(1, 0, 0, 0, 0, 0);
    #1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v.rst, v.we, v.wa, v.wd, v.r1, v.r2);
      exp_q.push_back(v);
      tick();
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL scoreboard_empty vec %0d", i);
      end else begin
        v = exp_q.pop_front();
        chk($sformatf("v%0d rd1", i), rd1, v.e1);
        chk($sformatf("v%0d rd2", i), rd2, v.e2);
        chk($sformatf("v%0d pend", i), {31'b0, pend},
            {31'b0, v.ep});
        chk($sformatf("v%0d rd1_nb", i), rd1_nb, v.e1nb);
        chk($sformatf("v%0d pend_nb", i), {31'b0, pend_nb},
            {31'b0, v.ep});
      end
    end

    // No same-cycle forwarding from the write inputs.
    drive(0, 1, 20, 32'hCAFE, 20, 20);
    #1;
    chk("nofwd rd1", rd1, 32'h0);
    chk("nofwd rd1_nb", rd1_nb, 32'h0);
    tick();
    chk("fwd rd1", rd1, 32'hCAFE);
    chk("fwd rd2", rd2, 32'hCAFE);
    chk("fwd rd1_nb", rd1_nb, 32'h0);
    drive(0, 0, 0, 0, 20, 20);
    tick();
    chk("commit rd1_nb", rd1_nb, 32'hCAFE);
    chk("commit rd2_nb", rd2_nb, 32'hCAFE);
    chk("commit pend", {31'b0, pend}, 32'h0);

    // Stack pointer is writable, then restored by reset.
    drive(0, 1, 29, 32'h100, 29, 0);
    tick();
    drive(0, 0, 0, 0, 29, 0);
    tick();
    chk("sp write nb", rd1_nb, 32'h100);
    drive(1, 0, 0, 0, 29, 20);
    tick();
    chk("sp reset", rd1, 32'd227);
    chk("r20 reset", rd2, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
